suma_mult_bcd: RTL and testbench

SUMA_MULT_BCD -- requirements
Module: suma_mult_bcd

---
 rtl/suma_mult_pkg.sv | 13 +
 rtl/suma_mult_add3.sv | 9 +
 rtl/suma_mult_bcd.sv | 110 +++++++++++
 tb/tb_suma_mult_bcd.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/suma_mult_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter
// that follows the sum-of-multiples core.
package suma_mult_pkg;

    localparam int unsigned BIN_W  = 32;
    localparam int unsigned DIGITS = 10;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned ITER   = 32;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_e;

endpackage

// File: rtl/suma_mult_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module suma_mult_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/suma_mult_bcd.sv
// Converts each new 32-bit result into ten BCD digits, one double-dabble
// iteration per cycle, with a single-entry pending slot for back-to-back results.
module suma_mult_bcd
    import suma_mult_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [BIN_W-1:0]   x_in,
    input  logic               x_valid,
    output logic [BCD_W-1:0]   bcd,
    output logic               done,
    output logic               busy,
    output logic               overrun
);

    state_e             r_state;
    logic               r_x_valid_q;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pend;
    logic [BIN_W-1:0]   r_pend_x;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_done;
    logic               r_overrun;

    logic               w_rise;
    logic               w_last;
    logic [BCD_W-1:0]   w_corr;
    logic [BCD_W-1:0]   w_scratch_nxt;
    logic [BIN_W-1:0]   w_shift_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        suma_mult_add3 u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_corr[4*g +: 4])
        );
    end

    assign w_rise        = x_valid & ~r_x_valid_q;
    assign w_last        = (r_cnt == CNT_W'(ITER - 1));
    assign w_scratch_nxt = {w_corr[BCD_W-2:0], r_shift[BIN_W-1]};
    assign w_shift_nxt   = {r_shift[BIN_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x_valid_q <= 1'b0;
            r_shift     <= '0;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_x    <= '0;
            r_bcd       <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_x_valid_q <= x_valid;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state   <= CONVERT;
                        r_shift   <= x_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                    end
                end
                CONVERT: begin
                    r_scratch <= w_scratch_nxt;
                    r_shift   <= w_shift_nxt;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd   <= w_scratch_nxt;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // A rise with nothing pending would only be parked and then
                    // picked up next cycle, so it is loaded straight away.
                    if (r_pend || w_rise) begin
                        r_state   <= CONVERT;
                        r_shift   <= r_pend ? r_pend_x : x_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_pend    <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Placed after the case so a new pending value wins over the clear above.
            if (w_rise && (r_state == CONVERT || (r_state == DONE && r_pend))) begin
                r_pend_x <= x_in;
                r_pend   <= 1'b1;
                if (r_pend && r_state == CONVERT) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign bcd     = r_bcd;
    assign done    = r_done;
    assign busy    = (r_state != IDLE);
    assign overrun = r_overrun;

endmodule

// File: tb/tb_suma_mult_bcd.sv
// Directed-vector bench for suma_mult_bcd with hand-computed BCD results.
module tb_suma_mult_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x_in;
    logic        x_valid;
    logic [39:0] bcd;
    logic        done;
    logic        busy;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int busy_cnt;
    int dn;

    always #5 clk = ~clk;

    suma_mult_bcd u_dut (
        .clk     (clk),
        .rst     (rst),
        .x_in    (x_in),
        .x_valid (x_valid),
        .bcd     (bcd),
        .done    (done),
        .busy    (busy),
        .overrun (overrun)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns having just passed the capture edge.
    task automatic pulse(input logic [31:0] v);
        x_in    = v;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (done) begin
                l = k;
                break;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        x_valid = 1'b0;
        x_in    = '0;
        repeat (3) tick();
        check("rst_bcd", bcd, 40'h0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        pulse(32'd12345);
        check("busy_e0", busy, 1);
        busy_cnt = 1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("lat_12345", lat, 32);
        check("bcd_12345", bcd, 40'h0000012345);
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
        check("busy_cycles", busy_cnt, 33);

        pulse(32'd0);
        wait_done(lat);
        check("bcd_zero", bcd, 40'h0000000000);
        tick();
        pulse(32'hFFFF_FFFF);
        wait_done(lat);
        check("bcd_max", bcd, 40'h4294967295);
        tick();
        check("bcd_hold", bcd, 40'h4294967295);

        pulse(32'd100);
        repeat (4) tick();
        pulse(32'd200);
        wait_done(lat);
        check("bcd_100", bcd, 40'h0000000100);
        wait_done(lat);
        check("lat_200", lat, 33);
        check("bcd_200", bcd, 40'h0000000200);
        check("no_overrun", overrun, 0);
        tick();

        pulse(32'd1);
        repeat (3) tick();
        pulse(32'd2);
        repeat (3) tick();
        pulse(32'd3);
        wait_done(lat);
        check("bcd_1", bcd, 40'h0000000001);
        wait_done(lat);
        check("lat_3", lat, 33);
        check("bcd_3", bcd, 40'h0000000003);
        check("overrun_set", overrun, 1);
        repeat (2) tick();
        check("overrun_sticky", overrun, 1);

        pulse(32'd999);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("abort_bcd", bcd, 40'h0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        rst = 1'b0;
        dn  = 0;
        repeat (40) begin
            tick();
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        pulse(32'd999);
        wait_done(lat);
        check("lat_999", lat, 32);
        check("bcd_999", bcd, 40'h0000000999);
        tick();

        // Rise landing in the DONE cycle while a value is already pending.
        pulse(32'd5);
        repeat (3) tick();
        pulse(32'd6);
        wait_done(lat);
        check("bcd_5", bcd, 40'h0000000005);
        x_in    = 32'd7;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        wait_done(lat);
        check("lat_6", lat, 32);
        check("bcd_6", bcd, 40'h0000000006);
        wait_done(lat);
        check("lat_7", lat, 33);
        check("bcd_7", bcd, 40'h0000000007);
        check("done_rise_no_overrun", overrun, 0);
        tick();

        x_in    = 32'd77;
        x_valid = 1'b1;
        dn      = 0;
        repeat (100) begin
            tick();
            if (done) dn++;
        end
        x_valid = 1'b0;
        repeat (5) tick();
        check("held_one_done", dn, 1);
        check("bcd_77", bcd, 40'h0000000077);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
